// File: rtl/wb_arbiter.sv
// wb_arbiter
//   Writeback stage in front of a single-port register file. Each producer
//   pushes (address, data) writebacks into its own small FIFO over a
//   valid/ready handshake. Every cycle one non-empty FIFO is chosen
//   round-robin and its head is driven out as a registered write request.
//   Read-after-write hazards are reported for two read addresses.
//
// Ports
//   clk_i        clock
//   reset_ni     asynchronous active-low reset
//   src_valid_i  per-source writeback valid
//   src_ready_o  per-source accept (FIFO not full)
//   src_addr_i   packed destination addresses, source s at slice s
//   src_data_i   packed writeback data, source s at slice s
//   wr_en_o      register-file write enable (registered)
//   wr_addr_o    register-file write address (registered)
//   wr_data_o    register-file write data (registered)
//   rd_addr_1_i  read port 1 address for hazard query
//   rd_addr_2_i  read port 2 address for hazard query
//   hazard_o     bit k set when a write to rd_addr_(k+1)_i is still pending
module wb_arbiter #(
  parameter int N_SRC         = 2,
  parameter int FIFO_DEPTH    = 2,
  parameter int REG_COUNT     = 32,
  parameter int REG_WIDTH     = 32,
  parameter bit HARDWIRE_ZERO = 1'b1
) (
  input  logic                                 clk_i,
  input  logic                                 reset_ni,
  input  logic [N_SRC-1:0]                     src_valid_i,
  output logic [N_SRC-1:0]                     src_ready_o,
  input  logic [N_SRC*$clog2(REG_COUNT)-1:0]   src_addr_i,
  input  logic [N_SRC*REG_WIDTH-1:0]           src_data_i,
  output logic                                 wr_en_o,
  output logic [$clog2(REG_COUNT)-1:0]         wr_addr_o,
  output logic [REG_WIDTH-1:0]                 wr_data_o,
  input  logic [$clog2(REG_COUNT)-1:0]         rd_addr_1_i,
  input  logic [$clog2(REG_COUNT)-1:0]         rd_addr_2_i,
  output logic [1:0]                           hazard_o
);

  localparam int AW = $clog2(REG_COUNT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(N_SRC);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] RR_INIT  = SW'(N_SRC - 1);

  // FIFO storage and bookkeeping
  logic [AW-1:0]        fifo_addr_r [N_SRC][FIFO_DEPTH];
  logic [REG_WIDTH-1:0] fifo_data_r [N_SRC][FIFO_DEPTH];
  logic [PW-1:0]        rd_ptr_r    [N_SRC];
  logic [PW-1:0]        wr_ptr_r    [N_SRC];
  logic [CW-1:0]        count_r     [N_SRC];

  // Arbitration and output registers
  logic [SW-1:0]        rr_ptr_r;
  logic                 wr_en_r;
  logic [AW-1:0]        wr_addr_r;
  logic [REG_WIDTH-1:0] wr_data_r;

  // Combinational helpers
  logic [AW-1:0]        in_addr_s [N_SRC];
  logic [REG_WIDTH-1:0] in_data_s [N_SRC];
  logic [N_SRC-1:0]     ready_s;
  logic [N_SRC-1:0]     push_s;
  logic [N_SRC-1:0]     pop_s;
  logic                 grant_valid_s;
  logic [SW-1:0]        grant_idx_s;
  logic [AW-1:0]        head_addr_s;
  logic [REG_WIDTH-1:0] head_data_s;
  logic                 hit_1_s;
  logic                 hit_2_s;
  logic                 zero_1_s;
  logic                 zero_2_s;

  // Unpack source buses, derive ready from the registered count only, and
  // qualify pushes; address-0 writes complete the handshake but are dropped.
  always_comb begin
    for (int s = 0; s < N_SRC; s++) begin
      in_addr_s[s] = src_addr_i[s*AW +: AW];
      in_data_s[s] = src_data_i[s*REG_WIDTH +: REG_WIDTH];
      ready_s[s]   = (count_r[s] != FULL_CNT);
      push_s[s]    = src_valid_i[s] & ready_s[s] &
                     ~(HARDWIRE_ZERO & (in_addr_s[s] == AW'(0)));
      pop_s[s]     = grant_valid_s & (grant_idx_s == SW'(s));
    end
  end

  // Ready is held low for the whole time reset is asserted.
  assign src_ready_o = ready_s & {N_SRC{reset_ni}};

  // Round-robin: first non-empty FIFO scanning upward from rr_ptr_r+1.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_idx_s   = {SW{1'b0}};
    for (int i = 1; i <= N_SRC; i++) begin
      logic [SW-1:0] scan_idx;
      scan_idx = SW'((int'(rr_ptr_r) + i) % N_SRC);
      if (!grant_valid_s && (count_r[scan_idx] != {CW{1'b0}})) begin
        grant_valid_s = 1'b1;
        grant_idx_s   = scan_idx;
      end else begin
        grant_valid_s = grant_valid_s;
        grant_idx_s   = grant_idx_s;
      end
    end
  end

  assign head_addr_s = fifo_addr_r[grant_idx_s][rd_ptr_r[grant_idx_s]];
  assign head_data_s = fifo_data_r[grant_idx_s][rd_ptr_r[grant_idx_s]];

  // FIFO storage writes; contents are only meaningful inside the count window.
  always_ff @(posedge clk_i) begin
    for (int s = 0; s < N_SRC; s++) begin
      if (push_s[s]) begin
        fifo_addr_r[s][wr_ptr_r[s]] <= in_addr_s[s];
        fifo_data_r[s][wr_ptr_r[s]] <= in_data_s[s];
      end
    end
  end

  // FIFO pointers and occupancy; push and pop together leave the count unchanged.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int s = 0; s < N_SRC; s++) begin
        rd_ptr_r[s] <= {PW{1'b0}};
        wr_ptr_r[s] <= {PW{1'b0}};
        count_r[s]  <= {CW{1'b0}};
      end
    end else begin
      for (int s = 0; s < N_SRC; s++) begin
        if (push_s[s]) begin
          wr_ptr_r[s] <= wr_ptr_r[s] + PW'(1);
        end
        if (pop_s[s]) begin
          rd_ptr_r[s] <= rd_ptr_r[s] + PW'(1);
        end
        case ({push_s[s], pop_s[s]})
          2'b10:   count_r[s] <= count_r[s] + CW'(1);
          2'b01:   count_r[s] <= count_r[s] - CW'(1);
          default: count_r[s] <= count_r[s];
        endcase
      end
    end
  end

  // Registered write request and round-robin pointer; address/data hold when idle.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rr_ptr_r  <= RR_INIT;
      wr_en_r   <= 1'b0;
      wr_addr_r <= {AW{1'b0}};
      wr_data_r <= {REG_WIDTH{1'b0}};
    end else if (grant_valid_s) begin
      rr_ptr_r  <= grant_idx_s;
      wr_en_r   <= 1'b1;
      wr_addr_r <= head_addr_s;
      wr_data_r <= head_data_s;
    end else begin
      wr_en_r   <= 1'b0;
    end
  end

  assign wr_en_o   = wr_en_r;
  assign wr_addr_o = wr_addr_r;
  assign wr_data_o = wr_data_r;

  // Hazard match against every occupied FIFO slot and the in-flight write.
  // A slot is occupied when its distance from the read pointer (modulo
  // depth) is below the count.
  always_comb begin
    hit_1_s = wr_en_r & (wr_addr_r == rd_addr_1_i);
    hit_2_s = wr_en_r & (wr_addr_r == rd_addr_2_i);
    for (int s = 0; s < N_SRC; s++) begin
      for (int e = 0; e < FIFO_DEPTH; e++) begin
        hit_1_s = hit_1_s | (({1'b0, PW'(e) - rd_ptr_r[s]} < count_r[s]) &
                             (fifo_addr_r[s][e] == rd_addr_1_i));
        hit_2_s = hit_2_s | (({1'b0, PW'(e) - rd_ptr_r[s]} < count_r[s]) &
                             (fifo_addr_r[s][e] == rd_addr_2_i));
      end
    end
    zero_1_s = HARDWIRE_ZERO & (rd_addr_1_i == AW'(0));
    zero_2_s = HARDWIRE_ZERO & (rd_addr_2_i == AW'(0));
  end

  assign hazard_o = {hit_2_s & ~zero_2_s, hit_1_s & ~zero_1_s};

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_t;

  logic            clk_i = 1'b0;
  logic            reset_ni = 1'b1;
  logic [1:0]      src_valid_i = 2'b00;
  logic [1:0]      src_ready_o;
  logic [2*AW-1:0] src_addr_i = '0;
  logic [2*DW-1:0] src_data_i = '0;
  logic            wr_en_o;
  logic [AW-1:0]   wr_addr_o;
  logic [DW-1:0]   wr_data_o;
  logic [AW-1:0]   rd_addr_1_i = '0;
  logic [AW-1:0]   rd_addr_2_i = '0;
  logic [1:0]      hazard_o;

  wb_arbiter #(
    .N_SRC(2), .FIFO_DEPTH(2), .REG_COUNT(32), .REG_WIDTH(32), .HARDWIRE_ZERO(1'b1)
  ) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
    .src_addr_i(src_addr_i), .src_data_i(src_data_i),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .rd_addr_1_i(rd_addr_1_i), .rd_addr_2_i(rd_addr_2_i),
    .hazard_o(hazard_o)
  );

  always #5 clk_i = ~clk_i;

  wb_t         q0[$];
  wb_t         q1[$];
  wb_t         exp_q[$];
  logic [DW-1:0] shadow [32];
  logic        rdy0_log [16];
  int          total = 0;
  int          bad = 0;
  int          tick_cnt = 0;
  int          last_wr = 0;
  int          gaps = 0;
  bit          have_prev = 1'b0;

  function automatic wb_t mk(input int a, input logic [DW-1:0] d);
    wb_t w;
    w.addr = AW'(a);
    w.data = d;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard side: every issued write must match the next expected one.
  task automatic mon();
    wb_t e;
    if (wr_en_o === 1'b1) begin
      chk("unexpected_write", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(wr_addr_o), 64'(e.addr));
        chk("wr_data", 64'(wr_data_o), 64'(e.data));
        shadow[wr_addr_o] = wr_data_o;
        if (have_prev && tick_cnt != last_wr + 1) gaps++;
        have_prev = 1'b1;
        last_wr = tick_cnt;
      end
    end
    tick_cnt++;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    mon();
  endtask

  task automatic do_reset();
    src_valid_i = 2'b00;
    reset_ni = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    reset_ni = 1'b1;
    exp_q.delete();
    q0.delete();
    q1.delete();
    tick();
    have_prev = 1'b0;
    gaps = 0;
  endtask

  // Drive both source queues concurrently, one cycle per iteration.
  task automatic run_streams(input int n, input bit must_finish);
    int cyc = 0;
    bit a0;
    bit a1;
    while ((q0.size() != 0 || q1.size() != 0) && cyc < n) begin
      src_valid_i[0] = (q0.size() != 0);
      src_valid_i[1] = (q1.size() != 0);
      if (q0.size() != 0) begin
        src_addr_i[AW-1:0] = q0[0].addr;
        src_data_i[DW-1:0] = q0[0].data;
      end
      if (q1.size() != 0) begin
        src_addr_i[2*AW-1:AW] = q1[0].addr;
        src_data_i[2*DW-1:DW] = q1[0].data;
      end
      #1;
      if (cyc < 16) rdy0_log[cyc] = src_ready_o[0];
      a0 = src_valid_i[0] & src_ready_o[0];
      a1 = src_valid_i[1] & src_ready_o[1];
      tick();
      if (a0) void'(q0.pop_front());
      if (a1) void'(q1.pop_front());
      cyc++;
    end
    src_valid_i = 2'b00;
    if (must_finish) chk("stream_timeout", 64'(q0.size() + q1.size()), 64'd0);
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      tick();
      k++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    repeat (3) tick();
  endtask

  initial begin
    logic exp_rdy [5];
    for (int i = 0; i < 32; i++) shadow[i] = '0;

    // Reset state
    #1 reset_ni = 1'b0;
    #2;
    chk("rst_wr_en", 64'(wr_en_o), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr_o), 64'd0);
    chk("rst_wr_data", 64'(wr_data_o), 64'd0);
    chk("rst_ready", 64'(src_ready_o), 64'd0);
    chk("rst_hazard", 64'(hazard_o), 64'd0);

    // Single write with hazard tracking
    do_reset();
    src_valid_i[0] = 1'b1;
    src_addr_i[AW-1:0] = AW'(5);
    src_data_i[DW-1:0] = 32'hDEADBEEF;
    rd_addr_1_i = AW'(5);
    rd_addr_2_i = AW'(6);
    exp_q.push_back(mk(5, 32'hDEADBEEF));
    #1;
    chk("single_ready", 64'(src_ready_o[0]), 64'd1);
    chk("single_hz_pre", 64'(hazard_o), 64'd0);
    tick();
    src_valid_i = 2'b00;
    chk("single_hz_E", 64'(hazard_o), 64'd1);
    chk("single_en_E", 64'(wr_en_o), 64'd0);
    rd_addr_1_i = AW'(9);
    rd_addr_2_i = AW'(5);
    tick();
    chk("single_en_E1", 64'(wr_en_o), 64'd1);
    chk("single_hz_E1", 64'(hazard_o), 64'd2);
    rd_addr_1_i = AW'(5);
    tick();
    chk("single_en_E2", 64'(wr_en_o), 64'd0);
    chk("single_hz_E2", 64'(hazard_o), 64'd0);
    drain();

    // Contention: strict alternation, no gaps
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      q0.push_back(mk(i, 32'hA000_0000 + i));
      q1.push_back(mk(10 + i, 32'hB000_0000 + i));
    end
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(mk(i, 32'hA000_0000 + i));
      exp_q.push_back(mk(10 + i, 32'hB000_0000 + i));
    end
    run_streams(40, 1'b1);
    drain();
    chk("contention_gaps", 64'(gaps), 64'd0);

    // Backpressure: src0 stalls once when its FIFO is full
    do_reset();
    for (int i = 1; i <= 4; i++) q0.push_back(mk(i, 32'hC000_0000 + i));
    for (int i = 1; i <= 6; i++) q1.push_back(mk(10 + i, 32'hD000_0000 + i));
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(mk(i, 32'hC000_0000 + i));
      exp_q.push_back(mk(10 + i, 32'hD000_0000 + i));
    end
    exp_q.push_back(mk(15, 32'hD000_0005));
    exp_q.push_back(mk(16, 32'hD000_0006));
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    run_streams(40, 1'b1);
    for (int i = 0; i < 5; i++) chk($sformatf("bp_ready0_c%0d", i), 64'(rdy0_log[i]), 64'(exp_rdy[i]));
    drain();
    chk("bp_gaps", 64'(gaps), 64'd0);

    // Zero register write is swallowed
    do_reset();
    src_valid_i[1] = 1'b1;
    src_addr_i[2*AW-1:AW] = AW'(0);
    src_data_i[2*DW-1:DW] = 32'h0000_1234;
    rd_addr_1_i = AW'(0);
    rd_addr_2_i = AW'(0);
    #1;
    chk("zero_ready", 64'(src_ready_o[1]), 64'd1);
    tick();
    src_valid_i = 2'b00;
    chk("zero_hazard", 64'(hazard_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("zero_wr_en_%0d", i), 64'(wr_en_o), 64'd0);
    end

    // Asynchronous reset in the middle of a stream
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      q0.push_back(mk(i, 32'hE000_0000 + i));
      q1.push_back(mk(10 + i, 32'hF000_0000 + i));
    end
    exp_q.push_back(mk(1, 32'hE000_0001));
    exp_q.push_back(mk(11, 32'hF000_0001));
    run_streams(3, 1'b0);
    rd_addr_1_i = AW'(2);
    rd_addr_2_i = AW'(3);
    #1;
    chk("pre_rst_hazard", 64'(hazard_o), 64'd3);
    #1 reset_ni = 1'b0;
    #1;
    chk("mid_rst_wr_en", 64'(wr_en_o), 64'd0);
    chk("mid_rst_ready", 64'(src_ready_o), 64'd0);
    chk("mid_rst_hazard", 64'(hazard_o), 64'd0);
    chk("mid_rst_exp_seen", 64'(exp_q.size()), 64'd0);
    q0.delete();
    q1.delete();
    @(negedge clk_i);
    @(negedge clk_i);
    reset_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("post_rst_wr_en_%0d", i), 64'(wr_en_o), 64'd0);
    end

    // Same-address race: src0 first, src1 last wins
    do_reset();
    q0.push_back(mk(7, 32'h0000_00AA));
    q1.push_back(mk(7, 32'h0000_00BB));
    exp_q.push_back(mk(7, 32'h0000_00AA));
    exp_q.push_back(mk(7, 32'h0000_00BB));
    run_streams(20, 1'b1);
    drain();
    chk("race_reg7", 64'(shadow[7]), 64'h0000_00BB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
